// File: rtl/add_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding
// and the default operand width.
package add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int ADD_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ADD  = ST_ADD,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full adder built from two half adders and an OR.
// This is the one shared datapath cell that the serial controller reuses
// for every bit position.
module full_adder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s1),
    .c_o (c1)
  );

  half_adder u_ha1 (
    .a_i (s1),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (c2)
  );

  assign c_o = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder: sum is the XOR of the inputs, carry is the AND.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder controller. Operands are captured on an
// accepted start and fed LSB first through one shared full-adder cell, one
// bit per clock, with a start/ready/done handshake.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed-overflow
// output 'ovf'.
module serial_add_ctrl
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_W_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum_shift;
  logic             fa_s;
  logic             fa_c;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder_bit u_fa (
    .a_i (a_sr_q[0]),
    .b_i (b_sr_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // New sum bit enters at the MSB; written this way so WIDTH=1 needs no
  // special case.
  assign sum_shift = {fa_s, sum_q};

  // State and datapath registers, cleared by synchronous active-low reset
  // so an operation in flight is simply dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and datapath sequencing; cout/ovf are loaded on the final
  // ADD edge so they are already valid during the DONE pulse.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d   = sum_shift[WIDTH:1];
        carry_d = fa_c;
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          cout_d  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_c;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == ADD);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: an 8-bit instance and a 1-bit
// instance share clock and reset. Expected results come from plain integer
// addition of the operands. Honours SERIAL_ADD_OVF_EN when defined.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start8;
  logic [W-1:0] a8;
  logic [W-1:0] b8;
  logic         cin8;
  logic         ready8;
  logic         busy8;
  logic         done8;
  logic [W-1:0] sum8;
  logic         cout8;
  logic         start1;
  logic         a1;
  logic         b1;
  logic         cin1;
  logic         ready1;
  logic         busy1;
  logic         done1;
  logic         sum1;
  logic         cout1;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf8;
  logic         ovf1;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .ready (ready8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .ready (ready1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf1)
`endif
  );

  // Reference: unsigned a + b + cin as a (W+1)-bit number.
  function automatic logic [W:0] refSum8(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Reference signed overflow: same-sign operands giving a different-sign result.
  function automatic logic refOvf8(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] s);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  // Runs one 8-bit add. Cycle n is the clock period ending at the n-th edge
  // after the accepting edge. Optionally pulses start with new A at pokeCycle.
  task automatic do_add8(input logic [W-1:0] opA, input logic [W-1:0] opB, input logic opC,
                         input int pokeCycle, input logic [W-1:0] pokeA,
                         output int doneCycle, output int notReadyCycles, output int busyCycles);
    doneCycle = -1;
    notReadyCycles = 0;
    busyCycles = 0;
    for (int w = 0; w < 20 && !ready8; w++) begin
      @(posedge clk); #1;
    end
    a8 = opA; b8 = opB; cin8 = opC; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = W'($urandom); b8 = W'($urandom); cin8 = 1'($urandom);
    for (int cyc = 1; cyc <= W + 6; cyc++) begin
      if (cyc == pokeCycle) begin
        start8 = 1'b1;
        a8 = pokeA;
      end else begin
        start8 = 1'b0;
      end
      if (!ready8) notReadyCycles++;
      if (busy8) busyCycles++;
      if (done8) begin
        doneCycle = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    start8 = 1'b0;
  endtask

  // Runs one add on the 1-bit instance; same cycle numbering as do_add8.
  task automatic do_add1(input logic opA, input logic opB, input logic opC, output int doneCycle);
    doneCycle = -1;
    for (int w = 0; w < 10 && !ready1; w++) begin
      @(posedge clk); #1;
    end
    a1 = opA; b1 = opB; cin1 = opC; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    a1 = ~opA; b1 = ~opB; cin1 = ~opC;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (done1) begin
        doneCycle = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    testsRun++; if (ready8 !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b expected 1", ready8); end
    testsRun++; if (busy8 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy8); end
    testsRun++; if (done8 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b expected 0", done8); end
    testsRun++; if (sum8 !== '0) begin testsFailed++; $display("[TB] FAIL reset_sum: got %h expected 00", sum8); end
    testsRun++; if (cout8 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_cout: got %b expected 0", cout8); end
    testsRun++; if (ready1 !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready_w1: got %b expected 1", ready1); end
`ifdef SERIAL_ADD_OVF_EN
    testsRun++; if (ovf8 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf8); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int dc, nr, bc;
    logic [W:0] expVal;
    // FF + 01 wraps to 00 with carry out
    do_add8(8'hFF, 8'h01, 1'b0, 0, 8'h00, dc, nr, bc);
    expVal = refSum8(8'hFF, 8'h01, 1'b0);
    testsRun++; if (dc != W + 1) begin testsFailed++; $display("[TB] FAIL basic1_latency: got %0d expected %0d", dc, W + 1); end
    testsRun++; if (sum8 !== expVal[W-1:0]) begin testsFailed++; $display("[TB] FAIL basic1_sum: got %h expected %h", sum8, expVal[W-1:0]); end
    testsRun++; if (cout8 !== expVal[W]) begin testsFailed++; $display("[TB] FAIL basic1_cout: got %b expected %b", cout8, expVal[W]); end
    @(posedge clk); #1;
    testsRun++; if (done8 !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic1_done_pulse: got %b expected 0", done8); end
    testsRun++; if (ready8 !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic1_ready_after: got %b expected 1", ready8); end
    testsRun++; if ({cout8, sum8} !== expVal) begin testsFailed++; $display("[TB] FAIL basic1_hold: got %h expected %h", {cout8, sum8}, expVal); end
    // 3C + 5A + 1
    do_add8(8'h3C, 8'h5A, 1'b1, 0, 8'h00, dc, nr, bc);
    expVal = refSum8(8'h3C, 8'h5A, 1'b1);
    testsRun++; if ({cout8, sum8} !== expVal) begin testsFailed++; $display("[TB] FAIL basic2_result: got %h expected %h", {cout8, sum8}, expVal); end
    testsRun++; if (nr != W + 1) begin testsFailed++; $display("[TB] FAIL basic2_not_ready_cycles: got %0d expected %0d", nr, W + 1); end
    testsRun++; if (bc != W) begin testsFailed++; $display("[TB] FAIL basic2_busy_cycles: got %0d expected %0d", bc, W); end
  endtask

  task automatic test_ignore_start();
    int dc, nr, bc;
    logic [W:0] expVal;
    do_add8(8'h3C, 8'h5A, 1'b1, 4, 8'h11, dc, nr, bc);
    expVal = refSum8(8'h3C, 8'h5A, 1'b1);
    testsRun++; if (dc != W + 1) begin testsFailed++; $display("[TB] FAIL ignore_latency: got %0d expected %0d", dc, W + 1); end
    testsRun++; if ({cout8, sum8} !== expVal) begin testsFailed++; $display("[TB] FAIL ignore_result: got %h expected %h", {cout8, sum8}, expVal); end
    @(posedge clk); #1;
    testsRun++; if (ready8 !== 1'b1) begin testsFailed++; $display("[TB] FAIL ignore_back_to_idle: got %b expected 1", ready8); end
  endtask

  task automatic test_abort();
    logic sawDone;
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    testsRun++; if (ready8 !== 1'b1) begin testsFailed++; $display("[TB] FAIL abort_ready: got %b expected 1", ready8); end
    testsRun++; if (busy8 !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_busy: got %b expected 0", busy8); end
    testsRun++; if (sum8 !== '0) begin testsFailed++; $display("[TB] FAIL abort_sum: got %h expected 00", sum8); end
    testsRun++; if (cout8 !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_cout: got %b expected 0", cout8); end
    rst_n = 1'b1;
    sawDone = done8;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done8) sawDone = 1'b1;
    end
    testsRun++; if (sawDone !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_no_done: got %b expected 0", sawDone); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x1, y1, x2, y2;
    logic c1, c2;
    logic [W:0] res1, res2;
    int firstDone, secondDone, doneCount;
    x1 = W'($urandom); y1 = W'($urandom); c1 = 1'($urandom);
    x2 = W'($urandom); y2 = W'($urandom); c2 = 1'($urandom);
    res1 = '0; res2 = '0;
    firstDone = -1; secondDone = -1; doneCount = 0;
    a8 = x1; b8 = y1; cin8 = c1; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = x2; b8 = y2; cin8 = c2;
    for (int cyc = 1; cyc <= 3 * W + 6; cyc++) begin
      if (done8) begin
        if (doneCount == 0) begin
          firstDone = cyc; res1 = {cout8, sum8};
        end else begin
          secondDone = cyc; res2 = {cout8, sum8};
        end
        doneCount++;
      end
      if (doneCount == 2) break;
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    testsRun++; if (firstDone != W + 1) begin testsFailed++; $display("[TB] FAIL b2b_first_latency: got %0d expected %0d", firstDone, W + 1); end
    testsRun++; if (secondDone != 2 * W + 3) begin testsFailed++; $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", secondDone, 2 * W + 3); end
    testsRun++; if (res1 !== refSum8(x1, y1, c1)) begin testsFailed++; $display("[TB] FAIL b2b_first_result: got %h expected %h", res1, refSum8(x1, y1, c1)); end
    testsRun++; if (res2 !== refSum8(x2, y2, c2)) begin testsFailed++; $display("[TB] FAIL b2b_second_result: got %h expected %h", res2, refSum8(x2, y2, c2)); end
    @(posedge clk); #1;
  endtask

  task automatic test_random8();
    int dc, nr, bc;
    logic [W-1:0] x, y;
    logic c;
    logic [W:0] expVal;
    for (int n = 0; n < 200; n++) begin
      x = W'($urandom); y = W'($urandom); c = 1'($urandom);
      if (n == 0) begin x = '1; y = '1; c = 1'b1; end
      if (n == 1) begin x = '0; y = '0; c = 1'b0; end
      do_add8(x, y, c, 0, 8'h00, dc, nr, bc);
      expVal = refSum8(x, y, c);
      testsRun++; if (dc != W + 1) begin testsFailed++; $display("[TB] FAIL rand8_latency: got %0d expected %0d (a=%h b=%h cin=%b)", dc, W + 1, x, y, c); end
      testsRun++; if ({cout8, sum8} !== expVal) begin testsFailed++; $display("[TB] FAIL rand8_result: got %h expected %h (a=%h b=%h cin=%b)", {cout8, sum8}, expVal, x, y, c); end
`ifdef SERIAL_ADD_OVF_EN
      testsRun++; if (ovf8 !== refOvf8(x, y, expVal[W-1:0])) begin testsFailed++; $display("[TB] FAIL rand8_ovf: got %b expected %b (a=%h b=%h cin=%b)", ovf8, refOvf8(x, y, expVal[W-1:0]), x, y, c); end
`endif
    end
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic test_ovf();
    int dc, nr, bc;
    do_add8(8'h7F, 8'h01, 1'b0, 0, 8'h00, dc, nr, bc);
    testsRun++; if (sum8 !== 8'h80) begin testsFailed++; $display("[TB] FAIL ovf1_sum: got %h expected 80", sum8); end
    testsRun++; if (ovf8 !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf1_ovf: got %b expected 1", ovf8); end
    do_add8(8'h80, 8'h80, 1'b0, 0, 8'h00, dc, nr, bc);
    testsRun++; if ({cout8, sum8} !== 9'h100) begin testsFailed++; $display("[TB] FAIL ovf2_result: got %h expected 100", {cout8, sum8}); end
    testsRun++; if (ovf8 !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf2_ovf: got %b expected 1", ovf8); end
    @(posedge clk); #1;
    testsRun++; if (ovf8 !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf2_hold: got %b expected 1", ovf8); end
  endtask
`endif

  task automatic test_width1();
    int dc;
    logic x, y, c;
    int total;
    do_add1(1'b1, 1'b1, 1'b1, dc);
    testsRun++; if (dc != 2) begin testsFailed++; $display("[TB] FAIL w1_latency: got %0d expected 2", dc); end
    testsRun++; if ({cout1, sum1} !== 2'b11) begin testsFailed++; $display("[TB] FAIL w1_result: got %b expected 11", {cout1, sum1}); end
    for (int n = 0; n < 1000; n++) begin
      x = 1'($urandom); y = 1'($urandom); c = 1'($urandom);
      total = int'(x) + int'(y) + int'(c);
      do_add1(x, y, c, dc);
      testsRun++;
      if (dc != 2 || {cout1, sum1} !== 2'(total)) begin
        testsFailed++;
        $display("[TB] FAIL w1_random: got done_cycle=%0d result=%b expected done_cycle=2 result=%b (a=%b b=%b cin=%b)", dc, {cout1, sum1}, 2'(total), x, y, c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_abort();
    test_back_to_back();
`ifdef SERIAL_ADD_OVF_EN
    test_ovf();
`endif
    test_random8();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation still running after 600000 time units, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
